xor_parity_pipe: RTL
====================

Name: xor_parity_pipe

Overview:
- Parametrised, pipelined successor to the team's single-bit XOR gate.
- Reduces a WIDTH-bit word to one parity bit through a registered two-level XOR tree. Supports even or odd parity, selected per word.
- Checks the computed parity against an incoming parity bit and reports errors. Provides a sticky error flag and an optional saturating error counter.
- Sits on a data path as a streaming generator/checker with a valid qualifier and no backpressure.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..64. Split point LO_W = WIDTH/2 (floor).
- CNT_W, 8, error counter width in bits; legal range 1..16. Used only when XOR_PAR_ERRCNT_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data, in_par and odd_mode are valid this cycle.
- in_data  input  WIDTH  data word.
- in_par  input  1  received parity bit to check.
- odd_mode  input  1  0 = even parity, 1 = odd parity; sampled with in_valid.
- clr  input  1  synchronous clear of err_sticky and err_cnt.
- out_valid  output  1  outputs below are valid.
- out_data  output  WIDTH  in_data delayed by 2 cycles.
- out_par  output  1  generated parity for out_data.
- par_err  output  1  one-cycle pulse: out_par != delayed in_par, qualified by out_valid.
- err_sticky  output  1  set on any par_err; cleared by clr.
- err_cnt  output  CNT_W  saturating error count; present only with XOR_PAR_ERRCNT_EN.

Behaviour:
- Reset: one clock; rst_n is asynchronous and active-low. All outputs and all internal pipeline registers are 0 while rst_n = 0. Release is synchronous to clk.
- Stage 1, cycle N+1 after acceptance at edge N:
  - register lo = XOR-reduce of in_data[LO_W-1:0];
  - register hi = XOR-reduce of in_data[WIDTH-1:LO_W];
  - register in_data, in_par, odd_mode and v1 = in_valid.
- Stage 2, cycle N+2:
  - out_par = lo ^ hi ^ odd_mode_s1;
  - out_data = data_s1; out_valid = v1;
  - par_err = v1 & (lo ^ hi ^ odd_mode_s1 ^ in_par_s1).
- Latency is fixed at 2 cycles, throughput 1 word/cycle. There is no stall input.
- Bubbles: when in_valid = 0 the stage registers still load, but the valid bits are 0. While out_valid = 0, par_err is 0, and out_data/out_par hold their last values (data registers enable on valid only).
- Parity definition:
  - even mode: out_par makes popcount(out_data) + out_par even;
  - odd mode: that total is odd.
- err_sticky: next = clr ? par_err_next : (err_sticky | par_err_next). An error in the same cycle as clr wins, so the flag stays 1.
- err_cnt:
  - clr alone -> 0;
  - error alone -> +1, saturating at 2^CNT_W-1 with no wrap;
  - clr and error in the same cycle -> 1.
- Reset mid-stream: words in flight are discarded and no out_valid is produced for them.
- odd_mode may change every cycle. Each word uses the value sampled with that word.

Optional Feature:
- Macro XOR_PAR_ERRCNT_EN.
- Defined: the err_cnt port and its counter exist as above.
- Undefined: the err_cnt port and its logic are absent, and CNT_W is ignored. All other behaviour is identical.

Test Plan:
- Even parity, no error: WIDTH=8, in_data=8'hA5, in_par=0, odd_mode=0 at edge 0 -> at edge 2: out_valid=1, out_data=8'hA5, out_par=0, par_err=0.
- Parity error: in_data=8'h07, in_par=0, even mode -> 2 cycles later: out_par=1, par_err=1 for one cycle, err_sticky=1, err_cnt=1.
- Odd mode and streaming: back-to-back words 8'hA5 (odd), 8'h01 (even), 8'hFF (odd) -> out_valid high 3 consecutive cycles; out_par = 1, 1, 1; no par_err when in_par matches.
- Counter saturation and clear (CNT_W=2): 5 consecutive error words -> err_cnt = 1, 2, 3, 3, 3. Then clr asserted in the same cycle as a 6th error -> err_cnt=1, err_sticky=1.
- Reset mid-stream: in_valid=1 at edge 0, rst_n=0 between edges 0 and 1, released before edge 2 -> out_valid, par_err, err_sticky and err_cnt all 0 through edge 4.
- Odd width WIDTH=5, even mode: in_data=5'b10110, in_par=1 -> out_par=1, par_err=0. Confirms the LO_W=2 split.

Source files
------------

// File: rtl/xor_parity_pipe.sv
// Two-stage pipelined parity generator/checker with sticky error flag.
// Define XOR_PAR_ERRCNT_EN to add the saturating err_cnt output.
module xor_parity_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_par,
    input  logic             odd_mode,
    input  logic             clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_par,
    output logic             par_err,
    output logic             err_sticky
`ifdef XOR_PAR_ERRCNT_EN
    ,
    output logic [CNT_W-1:0] err_cnt
`endif
);

    localparam int LO_W = WIDTH / 2;

    if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
        $error("xor_parity_pipe: WIDTH must be in 2..64");
    end
    if (CNT_W < 1 || CNT_W > 16) begin : g_bad_cnt_w
        $error("xor_parity_pipe: CNT_W must be in 1..16");
    end

    logic             lo_s1;
    logic             hi_s1;
    logic [WIDTH-1:0] data_s1;
    logic             par_s1;
    logic             odd_s1;
    logic             v1;

    logic             par_gen;
    logic             par_err_next;

    // Stage 1: split the reduction into two half-width trees.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_s1   <= 1'b0;
            hi_s1   <= 1'b0;
            data_s1 <= '0;
            par_s1  <= 1'b0;
            odd_s1  <= 1'b0;
            v1      <= 1'b0;
        end else begin
            lo_s1   <= ^in_data[LO_W-1:0];
            hi_s1   <= ^in_data[WIDTH-1:LO_W];
            data_s1 <= in_data;
            par_s1  <= in_par;
            odd_s1  <= odd_mode;
            v1      <= in_valid;
        end
    end

    always_comb begin
        par_gen      = lo_s1 ^ hi_s1 ^ odd_s1;
        par_err_next = v1 & (par_gen ^ par_s1);
    end

    // Stage 2: data and parity hold across bubbles; valid and error do not.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_par   <= 1'b0;
            par_err   <= 1'b0;
        end else begin
            out_valid <= v1;
            par_err   <= par_err_next;
            if (v1) begin
                out_data <= data_s1;
                out_par  <= par_gen;
            end
        end
    end

    // An error arriving with clr still sets the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sticky <= 1'b0;
        end else if (clr) begin
            err_sticky <= par_err_next;
        end else begin
            err_sticky <= err_sticky | par_err_next;
        end
    end

`ifdef XOR_PAR_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (clr) begin
            err_cnt <= par_err_next ? CNT_W'(1) : '0;
        end else if (par_err_next && (err_cnt != {CNT_W{1'b1}})) begin
            err_cnt <= err_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
